// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider:
// bus widths, FSM state encodings and handshake levels.
package div_unit_pkg;

    localparam int RegWidth = 32;

    typedef logic [RegWidth-1:0]   reg_bus_t;
    typedef logic [2*RegWidth-1:0] div_result_bus_t;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_unit_step.sv
// One restoring radix-2 iteration: shift in the next
// dividend bit, trial-subtract the divisor, emit one quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH:0]   dvs,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic           take;

    // trial subtraction; keep the shifted remainder when it goes negative
    always_comb begin
        shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
        take     = (shifted >= dvs);
        rem_next = take ? (shifted - dvs) : shifted;
        quo_next = {quo[WIDTH-2:0], take};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: one quotient bit per cycle,
// sign fix-up in a final cycle, cancellable at any point.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = RegWidth
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_start,
    input  logic               div_signed,
    input  logic [WIDTH-1:0]   div_opdata1,
    input  logic [WIDTH-1:0]   div_opdata2,
    input  logic               div_cancel,
    output logic               div_busy,
    output logic               div_ready,
    output logic [2*WIDTH-1:0] div_result
);

    localparam int CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    div_state_t      state;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   dvs;
    logic [WIDTH-1:0] quo;
    logic [CntW-1:0]  cnt;
    logic             neg_quo;
    logic             neg_rem;

    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] quo_fin;
    logic [WIDTH-1:0] rem_fin;
    logic             accept;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .dvs      (dvs),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    // operand magnitudes and final sign correction; 0x80000000 negates to
    // itself and is then read as unsigned 2^31
    always_comb begin
        accept  = (div_start == DivStart) && !div_cancel
                  && (div_ready == DivResultNotReady);
        a_abs   = (div_signed && div_opdata1[WIDTH-1]) ? -div_opdata1
                                                       : div_opdata1;
        b_abs   = (div_signed && div_opdata2[WIDTH-1]) ? -div_opdata2
                                                       : div_opdata2;
        quo_fin = neg_quo ? -quo : quo;
        rem_fin = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    assign div_busy = (state != DivFree);

    // divider FSM and datapath; cancel wins over every non-idle transition
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= DivFree;
            rem        <= '0;
            dvs        <= '0;
            quo        <= '0;
            cnt        <= '0;
            neg_quo    <= 1'b0;
            neg_rem    <= 1'b0;
            div_ready  <= DivResultNotReady;
            div_result <= '0;
        end else begin
            div_ready <= DivResultNotReady;
            unique case (state)
                DivFree: begin
                    if (accept) begin
                        if (div_opdata2 == '0) begin
                            state <= DivByZero;
                        end else begin
                            rem     <= '0;
                            quo     <= a_abs;
                            dvs     <= {1'b0, b_abs};
                            neg_quo <= div_signed
                                       & (div_opdata1[WIDTH-1]
                                          ^ div_opdata2[WIDTH-1]);
                            neg_rem <= div_signed & div_opdata1[WIDTH-1];
                            cnt     <= '0;
                            state   <= DivOn;
                        end
                    end
                end
                DivByZero: begin
                    if (div_cancel) begin
                        state <= DivFree;
                    end else begin
                        div_result <= '0;
                        div_ready  <= DivResultReady;
                        state      <= DivFree;
                    end
                end
                DivOn: begin
                    if (div_cancel) begin
                        state <= DivFree;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        cnt <= cnt + CntW'(1);
                        if (cnt == CntLast) begin
                            state <= DivEnd;
                        end
                    end
                end
                DivEnd: begin
                    if (div_cancel) begin
                        state <= DivFree;
                    end else begin
                        div_result <= {rem_fin, quo_fin};
                        div_ready  <= DivResultReady;
                        state      <= DivFree;
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, busy window, signed cases,
// divide by zero, cancel, mid-operation reset and back-to-back issue.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_opdata1;
    logic [31:0] div_opdata2;
    logic        div_cancel;
    logic        div_busy;
    logic        div_ready;
    logic [63:0] div_result;

    int checks = 0;
    int errors = 0;

    div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .div_start   (div_start),
        .div_signed  (div_signed),
        .div_opdata1 (div_opdata1),
        .div_opdata2 (div_opdata2),
        .div_cancel  (div_cancel),
        .div_busy    (div_busy),
        .div_ready   (div_ready),
        .div_result  (div_result)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue in the current cycle (C0), wait for ready with a bound.
    // lat = cycle index of the ready pulse; bad = busy-window violations.
    task automatic div_op(input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic keep,
                          output int lat, output logic [63:0] res,
                          output int bad);
        div_start   = 1'b1;
        div_signed  = sg;
        div_opdata1 = a;
        div_opdata2 = b;
        lat = 0;
        bad = 0;
        while (lat < 60) begin
            step();
            lat++;
            if (div_ready) break;
            if (div_busy !== 1'b1) bad++;
        end
        if (div_busy !== 1'b0) bad++;
        res = div_result;
        if (!keep) div_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        div_start = 1'b0;
        div_signed = 1'b0;
        div_opdata1 = '0;
        div_opdata2 = '0;
        div_cancel = 1'b0;
        step();
        step();
        checks++;
        if (div_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", div_busy);
        end
        checks++;
        if (div_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", div_ready);
        end
        checks++;
        if (div_result !== 64'h0) begin
            errors++;
            $display("FAIL reset_result: got %h want 0", div_result);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_divu_basic();
        int lat;
        int bad;
        logic [63:0] res;
        div_op(1'b0, 32'd100, 32'd7, 1'b0, lat, res, bad);
        checks++;
        if (lat != 34) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 34", lat);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_busy: got %0d bad cycles want 0", bad);
        end
        checks++;
        if (res !== 64'h00000002_0000000E) begin
            errors++;
            $display("FAIL basic_result: got %h want %h",
                     res, 64'h00000002_0000000E);
        end
        step();
        checks++;
        if (div_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse: got %b want 0", div_ready);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        int bad;
        logic [63:0] res;
        div_op(1'b0, 32'd5, 32'd0, 1'b0, lat, res, bad);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL zero_latency: got %0d want 2", lat);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL zero_busy: got %0d bad cycles want 0", bad);
        end
        checks++;
        if (res !== 64'h0) begin
            errors++;
            $display("FAIL zero_result: got %h want 0", res);
        end
        step();
    endtask

    task automatic test_signed();
        logic        sg [5];
        logic [31:0] av [5];
        logic [31:0] bv [5];
        logic [63:0] ev [5];
        int lat;
        int bad;
        logic [63:0] res;
        sg[0] = 1'b1; av[0] = 32'hFFFFFFF9; bv[0] = 32'd2;
        ev[0] = 64'hFFFFFFFF_FFFFFFFD;
        sg[1] = 1'b1; av[1] = 32'd7; bv[1] = 32'hFFFFFFFE;
        ev[1] = 64'h00000001_FFFFFFFD;
        sg[2] = 1'b0; av[2] = 32'hFFFFFFFF; bv[2] = 32'd1;
        ev[2] = 64'h00000000_FFFFFFFF;
        sg[3] = 1'b1; av[3] = 32'h80000000; bv[3] = 32'hFFFFFFFF;
        ev[3] = 64'h00000000_80000000;
        sg[4] = 1'b0; av[4] = 32'h80000000; bv[4] = 32'd3;
        ev[4] = 64'h00000002_2AAAAAAA;
        for (int i = 0; i < 5; i++) begin
            div_op(sg[i], av[i], bv[i], 1'b0, lat, res, bad);
            checks++;
            if (res !== ev[i] || lat != 34) begin
                errors++;
                $display("FAIL signed_vec%0d: got %h lat %0d want %h lat 34",
                         i, res, lat, ev[i]);
            end
            step();
        end
    endtask

    task automatic test_cancel();
        int lat;
        int bad;
        int seen;
        logic [63:0] res;
        seen = 0;
        div_start   = 1'b1;
        div_signed  = 1'b0;
        div_opdata1 = 32'd100;
        div_opdata2 = 32'd7;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (div_ready) seen++;
        end
        div_cancel = 1'b1;
        div_start  = 1'b0;
        step();
        if (div_ready) seen++;
        checks++;
        if (div_busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_busy: got %b want 0", div_busy);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL cancel_ready: got %0d pulses want 0", seen);
        end
        checks++;
        if (div_result !== 64'h00000002_2AAAAAAA) begin
            errors++;
            $display("FAIL cancel_hold: got %h want %h",
                     div_result, 64'h00000002_2AAAAAAA);
        end
        div_cancel = 1'b0;
        div_op(1'b0, 32'd9, 32'd4, 1'b0, lat, res, bad);
        checks++;
        if (lat != 34 || res !== 64'h00000001_00000002) begin
            errors++;
            $display("FAIL cancel_restart: got %h lat %0d want %h lat 34",
                     res, lat, 64'h00000001_00000002);
        end
        step();
        div_start  = 1'b1;
        div_cancel = 1'b1;
        step();
        div_start  = 1'b0;
        div_cancel = 1'b0;
        checks++;
        if (div_busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_idle_start: got busy %b want 0", div_busy);
        end
        step();
    endtask

    task automatic test_reset_mid();
        div_start   = 1'b1;
        div_signed  = 1'b0;
        div_opdata1 = 32'd100;
        div_opdata2 = 32'd7;
        for (int c = 1; c <= 20; c++) step();
        rst = 1'b0;
        step();
        checks++;
        if (div_busy !== 1'b0 || div_ready !== 1'b0 || div_result !== 64'h0)
        begin
            errors++;
            $display("FAIL reset_mid: got busy %b ready %b result %h want 0 0 0",
                     div_busy, div_ready, div_result);
        end
        rst = 1'b1;
        div_start = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad;
        logic [63:0] res;
        div_op(1'b0, 32'd20, 32'd3, 1'b1, lat, res, bad);
        checks++;
        if (lat != 34 || res !== 64'h00000002_00000006) begin
            errors++;
            $display("FAIL b2b_first: got %h lat %0d want %h lat 34",
                     res, lat, 64'h00000002_00000006);
        end
        div_signed  = 1'b1;
        div_opdata1 = 32'hFFFFFFF0;
        div_opdata2 = 32'd5;
        step();
        checks++;
        if (div_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_relaunch: got busy %b want 0", div_busy);
        end
        div_op(1'b1, 32'hFFFFFFF0, 32'd5, 1'b0, lat, res, bad);
        checks++;
        if (lat != 34 || bad != 0) begin
            errors++;
            $display("FAIL b2b_second_timing: got lat %0d bad %0d want 34 0",
                     lat, bad);
        end
        checks++;
        if (res !== 64'hFFFFFFFF_FFFFFFFD) begin
            errors++;
            $display("FAIL b2b_second_result: got %h want %h",
                     res, 64'hFFFFFFFF_FFFFFFFD);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_div_zero();
        test_signed();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
